// File: rtl/uart_pkg.sv
// Shared receive-side definitions: framer state encoding and the TXBUF-compatible frame packer.
package uart_pkg;

    localparam int unsigned FRAME_DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Frame layout matches the transmitter buffer: stop bit on top, start bit in bit 0.
    function automatic logic [FRAME_DATA_W+1:0] frame_pack(input logic [FRAME_DATA_W-1:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; resets to 1 so an idle line
// never looks like a start edge coming out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_frame_engine.sv
// 8N1 UART receive framer with a DEPTH-entry history of received frames.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_frame_engine
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               rx_serial,
    input  logic                               buf_clr,
    output logic [WIDTH-1:0]                   rx_data,
    output logic                               rx_valid,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               rx_busy,
    output logic [DEPTH-1:0][WIDTH+1:0]        rx_buf,
    output logic [$clog2(DEPTH+1)-1:0]         rx_fill
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(WIDTH + 1);
    localparam int FILL_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic s;

    rx_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]           shift_q, shift_d;
    logic [WIDTH-1:0]           rx_data_q, rx_data_d;
    logic                       rx_valid_q;
    logic                       frame_err_q, frame_err_d;
    logic                       parity_err_q, parity_err_d;
    logic [DEPTH-1:0][WIDTH+1:0] buf_q, buf_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic                       push;
    logic                       cell_end;
    logic [WIDTH+1:0]           framed;
`ifdef UART_RX_PARITY_EN
    logic                       par_bad_q, par_bad_d;
`endif

    uart_rx_sync u_rx_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (rx_serial),
        .sync_o  (s)
    );

    if (WIDTH == FRAME_DATA_W) begin : g_pkg_frame
        assign framed = frame_pack(shift_q);
    end else begin : g_generic_frame
        assign framed = {1'b1, shift_q, 1'b0};
    end

    assign cell_end = (cnt_q == CNT_LAST);

    // Framer: the start bit is re-checked at half a cell, which puts every later sample mid-cell.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        push         = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    state_d   = s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cell_end) begin
                    cnt_d     = '0;
                    shift_d   = {s, shift_q[WIDTH-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cell_end) begin
                    cnt_d   = '0;
                    state_d = RX_STOP;
                    if (s != ^shift_q) begin
                        parity_err_d = 1'b1;
                        par_bad_d    = 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (cell_end) begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                        push    = !par_bad_q;
`else
                        push    = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (s) state_d = RX_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // A clear coinciding with a push leaves only the new frame behind.
    always_comb begin
        buf_d     = buf_q;
        fill_d    = fill_q;
        rx_data_d = rx_data_q;
        if (buf_clr) begin
            buf_d  = '0;
            fill_d = '0;
        end
        if (push) begin
            buf_d     = {buf_d[DEPTH-2:0], framed};
            fill_d    = (fill_d == FILL_MAX) ? fill_d : fill_d + 1'b1;
            rx_data_d = shift_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            buf_q        <= '0;
            fill_q       <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= push;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign rx_busy    = (state_q != RX_IDLE);
    assign rx_buf     = buf_q;
    assign rx_fill    = fill_q;

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Scoreboard bench for uart_rx_frame_engine: stimulus queues expected frames, a monitor checks
// every rx_valid strobe. Honours UART_RX_PARITY_EN when the design is built with it.
module tb_uart_rx_frame_engine;

    localparam int CPB    = 16;
    localparam int W      = 8;
    localparam int D      = 4;
    localparam int FILL_W = $clog2(D + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rx_serial;
    logic                 buf_clr;
    logic [W-1:0]         rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 rx_busy;
    logic [D-1:0][W+1:0]  rx_buf;
    logic [FILL_W-1:0]    rx_fill;

    typedef struct {
        logic [W-1:0]         data;
        logic [D*(W+2)-1:0]   hist;
        int                   fill;
    } exp_t;

    exp_t         expQ[$];
    logic [W+1:0] modelHist[$];
    int checks   = 0;
    int errors   = 0;
    int ferrSeen = 0;
    int ferrExp  = 0;
    int perrSeen = 0;
    int perrExp  = 0;
`ifdef UART_RX_PARITY_EN
    bit parFlip  = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_frame_engine #(.WIDTH(W), .DEPTH(D), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .buf_clr    (buf_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy),
        .rx_buf     (rx_buf),
        .rx_fill    (rx_fill)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] frameOf(input logic [W-1:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    function automatic logic [D*(W+2)-1:0] packHist();
        logic [D*(W+2)-1:0] r = '0;
        for (int i = 0; i < modelHist.size(); i++) r[i*(W+2) +: (W+2)] = modelHist[i];
        return r;
    endfunction

    // Reference history: newest frame at the front, oldest beyond DEPTH falls off the back.
    task automatic modelPush(input logic [W-1:0] b);
        exp_t e;
        modelHist.push_front(frameOf(b));
        if (modelHist.size() > D) void'(modelHist.pop_back());
        e.data = b;
        e.hist = packHist();
        e.fill = modelHist.size();
        expQ.push_back(e);
    endtask

    task automatic driveCell(input logic v);
        @(negedge clk);
        rx_serial = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [W-1:0] b, input logic stopBit);
        driveCell(1'b0);
        for (int i = 0; i < W; i++) driveCell(b[i]);
`ifdef UART_RX_PARITY_EN
        driveCell((^b) ^ parFlip);
`endif
        driveCell(stopBit);
    endtask

    task automatic sendGood(input logic [W-1:0] b);
        modelPush(b);
        applyStimulus(b, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedValid: got rx_data 0x%0h, expected no strobe", rx_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rxData", rx_data, e.data);
                    checkOutput("rxBuf", rx_buf, e.hist);
                    checkOutput("rxFill", rx_fill, e.fill);
                end
            end
            if (frame_err) ferrSeen++;
            if (parity_err) perrSeen++;
        end
    end

    initial begin
        logic [7:0] b;
        bit found;
        reset     = 1'b1;
        rx_serial = 1'b1;
        buf_clr   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetData", rx_data, 0);
        checkOutput("resetBuf", rx_buf, 0);
        checkOutput("resetFill", rx_fill, 0);
        checkOutput("resetValid", rx_valid, 0);
        checkOutput("resetFerr", frame_err, 0);
        checkOutput("resetPerr", parity_err, 0);
        checkOutput("resetBusy", rx_busy, 0);
        reset = 1'b0;
        idleCycles(2 * CPB);

        // Single frame
        sendGood(8'hA5);
        idleCycles(2 * CPB);
        checkOutput("a5Entry", rx_buf[0], 10'b1101001010);
        checkOutput("a5Fill", rx_fill, 1);

        // Back-to-back frames overflow the history
        for (int i = 1; i <= 5; i++) sendGood(8'(i));
        idleCycles(2 * CPB);
        checkOutput("b2bBuf", rx_buf, {frameOf(8'h02), frameOf(8'h03), frameOf(8'h04), frameOf(8'h05)});
        checkOutput("b2bFill", rx_fill, 4);

        // Short glitch on an idle line
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitchBusy", rx_busy, 1);
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitchIdle", rx_busy, 0);
        checkOutput("glitchBuf", rx_buf, packHist());
        checkOutput("glitchFill", rx_fill, modelHist.size());

        // Bad stop bit followed by a held-low break
        ferrExp++;
        applyStimulus(8'h3C, 1'b0);
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idleCycles(2 * CPB);
        checkOutput("breakFerrCount", ferrSeen, ferrExp);
        checkOutput("breakBuf", rx_buf, packHist());
        sendGood(8'h55);
        idleCycles(CPB);

        // Reset during the data bits of 0xFF
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("midFrameBusy", rx_busy, 1);
        reset = 1'b1;
        #1;
        modelHist.delete();
        checkOutput("midResetData", rx_data, 0);
        checkOutput("midResetBuf", rx_buf, 0);
        checkOutput("midResetFill", rx_fill, 0);
        checkOutput("midResetBusy", rx_busy, 0);
        checkOutput("midResetValid", rx_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8 * CPB) @(negedge clk);
        sendGood(8'h12);
        idleCycles(2 * CPB);
        checkOutput("afterResetFill", rx_fill, 1);

        // Clear coinciding with a push
        modelHist.delete();
        modelPush(8'h77);
        fork
            applyStimulus(8'h77, 1'b1);
            begin
                repeat (150) @(posedge clk);
                #1;
                buf_clr = 1'b1;
                found   = 1'b0;
                for (int k = 0; k < 30 && !found; k++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid) found = 1'b1;
                end
                buf_clr = 1'b0;
                checkOutput("clrPushSeen", found, 1);
            end
        join
        idleCycles(CPB);
        checkOutput("clrPushData", rx_data, 8'h77);

`ifdef UART_RX_PARITY_EN
        parFlip = 1'b1;
        perrExp++;
        applyStimulus(8'h0F, 1'b1);
        parFlip = 1'b0;
        idleCycles(2 * CPB);
        checkOutput("parityFill", rx_fill, modelHist.size());
`endif

        // Randomized traffic with occasional idle-time clears
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                buf_clr = 1'b1;
                @(negedge clk);
                buf_clr = 1'b0;
                modelHist.delete();
            end
            sendGood(b);
            idleCycles(int'($urandom_range(0, 2)) * CPB + int'($urandom_range(0, 7)));
        end
        idleCycles(3 * CPB);

        checkOutput("finalBuf", rx_buf, packHist());
        checkOutput("finalFill", rx_fill, modelHist.size());
        checkOutput("ferrTotal", ferrSeen, ferrExp);
        checkOutput("perrTotal", perrSeen, perrExp);
        checkOutput("pendingFrames", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
